// File: rtl/multicycle_slice_adder_pkg.sv
// Shared definitions for the multicycle slice adder: slice width and FSM state codes.
// Code 2'd3 is never produced; the top level treats it like IDLE.
package multicycle_slice_adder_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/multicycle_slice_adder_slice4.sv
// Purely combinational 4-bit adder slice: four full-adder bit cells in a ripple chain.
module adder_slice4
  import multicycle_slice_adder_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout
);

  logic [SLICE_W:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
    assign s[i]         = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[SLICE_W];

endmodule

// File: rtl/multicycle_slice_adder.sv
// Sequential wide adder: one 4-bit slice per clock through a shared slice and a registered carry,
// with valid/ready handshakes on the operand and result sides.
module multicycle_slice_adder
  import multicycle_slice_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_e             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [IDX_W-1:0]   idx_q;
  logic               c_q;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;
  logic               ovf_q;

  logic [SLICE_W-1:0] slice_sum_d;
  logic               slice_carry_d;
  logic [IDX_W+1:0]   base;

  assign base = {idx_q, 2'b00};

  adder_slice4 u_slice (
    .a    (a_q[base +: SLICE_W]),
    .b    (b_q[base +: SLICE_W]),
    .cin  (c_q),
    .s    (slice_sum_d),
    .cout (slice_carry_d)
  );

  // The unused state code falls through to the IDLE branch, so it can never lock up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      c_q     <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (state_q == RUN) begin
      sum_q[base +: SLICE_W] <= slice_sum_d;
      c_q                    <= slice_carry_d;
      if (idx_q == IDX_W'(NSLICE - 1)) begin
        cout_q  <= slice_carry_d;
        ovf_q   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_sum_d[SLICE_W-1] != a_q[WIDTH-1]);
        state_q <= DONE;
      end else begin
        idx_q <= idx_q + IDX_W'(1);
      end
    end else if (state_q == DONE) begin
      if (out_ready) begin
        state_q <= IDLE;
      end
    end else begin
      if (in_valid) begin
        a_q     <= a;
        b_q     <= b;
        c_q     <= cin;
        idx_q   <= '0;
        state_q <= RUN;
      end
    end
  end

  assign in_ready  = (state_q != RUN) && (state_q != DONE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_multicycle_slice_adder.sv
// Directed self-checking bench for multicycle_slice_adder (WIDTH=16, four slices).
module tb_multicycle_slice_adder;

  localparam int WIDTH   = 16;
  localparam int NSLICE  = WIDTH / 4;
  localparam int MAXWAIT = 40;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int checks = 0;
  int errors = 0;

  multicycle_slice_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Every comparison funnels through here so the counters and FAIL lines stay uniform.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Presents operands from a falling edge, waits for acceptance, then counts rising edges
  // until out_valid is seen; latency is the number of edges after the acceptance edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] opA, input logic [WIDTH-1:0] opB,
                               input logic opCin, output int latency);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < MAXWAIT) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("in_ready_wait", {31'd0, in_ready}, 32'd1);
    a        = opA;
    b        = opB;
    cin      = opCin;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    latency  = 0;
    do begin
      @(posedge clk);
      latency++;
      @(negedge clk);
    end while (!out_valid && latency < MAXWAIT);
  endtask

  task automatic checkResult(input string tag, input logic [WIDTH-1:0] expSum,
                             input logic expCout, input logic expOvf);
    checkOutput({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    checkOutput({tag, "_sum"}, {16'd0, sum}, {16'd0, expSum});
    checkOutput({tag, "_cout"}, {31'd0, cout}, {31'd0, expCout});
    checkOutput({tag, "_ovf"}, {31'd0, ovf}, {31'd0, expOvf});
    checkOutput({tag, "_in_ready_done"}, {31'd0, in_ready}, 32'd0);
  endtask

  // Completes the output handshake and confirms the block is back in IDLE.
  task automatic releaseResult(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    checkOutput({tag, "_in_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int lat;

    #12;
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_sum", {16'd0, sum}, 32'd0);
    checkOutput("reset_cout", {31'd0, cout}, 32'd0);
    checkOutput("reset_ovf", {31'd0, ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(16'h1234, 16'h4321, 1'b0, lat);
    checkOutput("basic_latency", lat, NSLICE);
    checkResult("basic", 16'h5555, 1'b0, 1'b0);
    releaseResult("basic");

    applyStimulus(16'hFFFF, 16'h0001, 1'b0, lat);
    checkOutput("ripple_latency", lat, NSLICE);
    checkResult("ripple", 16'h0000, 1'b1, 1'b0);
    releaseResult("ripple");

    applyStimulus(16'h7FFF, 16'h0001, 1'b0, lat);
    checkResult("posovf", 16'h8000, 1'b0, 1'b1);
    releaseResult("posovf");

    applyStimulus(16'h8000, 16'h8000, 1'b0, lat);
    checkResult("negovf", 16'h0000, 1'b1, 1'b1);
    releaseResult("negovf");

    applyStimulus(16'h0000, 16'hFFFF, 1'b1, lat);
    checkResult("cin", 16'h0000, 1'b1, 1'b0);
    releaseResult("cin");

    // Backpressure: result frozen while new operands toggle at the input.
    out_ready = 1'b0;
    applyStimulus(16'h1234, 16'h1111, 1'b1, lat);
    checkResult("bp_start", 16'h2346, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      a        = (i % 2 == 0) ? 16'hAAAA : 16'h5555;
      b        = 16'h0F0F ^ WIDTH'(i);
      cin      = i[0];
      in_valid = ~in_valid;
      @(posedge clk);
      @(negedge clk);
      checkResult($sformatf("bp_hold%0d", i), 16'h2346, 1'b0, 1'b0);
    end
    in_valid = 1'b0;
    releaseResult("bp");

    // Reset during the second RUN cycle abandons the operation.
    @(negedge clk);
    a        = 16'h1111;
    b        = 16'h2222;
    cin      = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_sum", {16'd0, sum}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("post_rst_out_valid", {31'd0, out_valid}, 32'd0);

    applyStimulus(16'h0F0F, 16'h00F1, 1'b0, lat);
    checkOutput("post_rst_latency", lat, NSLICE);
    checkResult("post_rst", 16'h1000, 1'b0, 1'b0);
    releaseResult("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
